// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: registered N:1 data multiplexer with manual and scan modes.
//
// Purpose:
//   Puts one of CHANNELS input words onto a registered output. In manual mode an external
//   select chooses the channel. In scan mode an internal counter steps through the channels
//   in order and stays DWELL cycles on each one. The output register and the channel register
//   load on the same edge, so o_mux_out always comes from the channel reported on o_cur_ch.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset (wins over everything)
//   i_mode       0 = manual, 1 = scan
//   i_sel        manual-mode channel select; values >= CHANNELS are ignored
//   i_hold       freezes channel, dwell counter and output
//   i_in_bus     packed inputs, channel k = i_in_bus[k*WIDTH +: WIDTH]
//   o_mux_out    registered selected data
//   o_cur_ch     channel currently driving o_mux_out
//   o_ch_change  one-cycle pulse after an edge that changed o_cur_ch
module mux_nto1_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DWELL    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic                      i_hold,
  input  logic [WIDTH*CHANNELS-1:0] i_in_bus,
  output logic [WIDTH-1:0]          o_mux_out,
  output logic [SEL_W-1:0]          o_cur_ch,
  output logic                      o_ch_change
);

  // Dwell counter needs at least one bit even when DWELL is 1.
  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  // One extra bit so CHANNELS = 2^SEL_W is still representable for the range check.
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] r_cur_ch;
  logic [DW_W-1:0]  r_dwell;
  logic [WIDTH-1:0] r_mux_out;
  logic             r_ch_change;

  logic             w_sel_ok;
  logic             w_dwell_done;
  logic [SEL_W-1:0] w_ch_inc;
  logic [SEL_W-1:0] w_next_ch;
  logic [DW_W-1:0]  w_dwell_d;
  logic [WIDTH-1:0] w_next_data;

  assign w_sel_ok     = ({1'b0, i_sel} < CH_LIMIT);
  assign w_dwell_done = (r_dwell == DWELL_LAST);

  // Explicit wrap at the last real channel: unused codes of a non-power-of-two
  // channel count are never visited.
  assign w_ch_inc = (r_cur_ch == LAST_CH) ? '0 : (r_cur_ch + SEL_W'(1));

  // Next channel and next dwell count.
  always_comb begin
    w_next_ch = r_cur_ch;
    w_dwell_d = '0;
    if (!i_mode) begin
      if (w_sel_ok) begin
        w_next_ch = i_sel;
      end
    end else if (w_dwell_done) begin
      w_next_ch = w_ch_inc;
    end else begin
      w_dwell_d = r_dwell + DW_W'(1);
    end
  end

  // Data mux on the next channel, so data and channel register together.
  always_comb begin
    w_next_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_next_ch == SEL_W'(k)) begin
        w_next_data = i_in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur_ch    <= '0;
      r_dwell     <= '0;
      r_mux_out   <= '0;
      r_ch_change <= 1'b0;
    end else if (i_hold) begin
      r_ch_change <= 1'b0;
    end else begin
      r_cur_ch    <= w_next_ch;
      r_dwell     <= w_dwell_d;
      r_mux_out   <= w_next_data;
      r_ch_change <= (w_next_ch != r_cur_ch);
    end
  end

  assign o_mux_out   = r_mux_out;
  assign o_cur_ch    = r_cur_ch;
  assign o_ch_change = r_ch_change;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Testbench for mux_nto1_scan: three builds (4 ch / dwell 4, 3 ch / dwell 4, 5 ch / dwell 1)
// share one stimulus. A directed table checks the 4-channel build against fixed values, a
// short hand sequence checks the 3-channel wrap and ignored select, and random stimulus is
// compared for all builds against a channel-level reference model.
module tb_mux_nto1_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  sel = '0;
  logic [63:0] bus = '0;

  logic [7:0] out4, out3, out5;
  logic [1:0] ch4, ch3;
  logic [2:0] ch5;
  logic       chg4, chg3, chg5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_nto1_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel[1:0]), .i_hold(hold),
    .i_in_bus(bus[31:0]), .o_mux_out(out4), .o_cur_ch(ch4), .o_ch_change(chg4)
  );

  mux_nto1_scan #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(4)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel[1:0]), .i_hold(hold),
    .i_in_bus(bus[23:0]), .o_mux_out(out3), .o_cur_ch(ch3), .o_ch_change(chg3)
  );

  mux_nto1_scan #(.WIDTH(8), .CHANNELS(5), .SEL_W(3), .DWELL(1)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel[2:0]), .i_hold(hold),
    .i_in_bus(bus[39:0]), .o_mux_out(out5), .o_cur_ch(ch5), .o_ch_change(chg5)
  );

  // Reference model: channel index and dwell position as plain integers.
  typedef struct {
    int ch;
    int dw;
    int out;
    int chg;
  } mst_t;

  mst_t m4 = '{0, 0, 0, 0};
  mst_t m3 = '{0, 0, 0, 0};
  mst_t m5 = '{0, 0, 0, 0};

  function automatic mst_t mstep(mst_t s, int chn, int dwl, bit r, bit h, bit md, int sl,
                                 logic [63:0] b);
    mst_t n;
    int   nx;
    n = s;
    if (r) begin
      n = '{0, 0, 0, 0};
    end else if (h) begin
      n.chg = 0;
    end else begin
      nx = s.ch;
      if (!md) begin
        if (sl < chn) nx = sl;
        n.dw = 0;
      end else if (s.dw == dwl - 1) begin
        nx   = (s.ch + 1) % chn;
        n.dw = 0;
      end else begin
        n.dw = s.dw + 1;
      end
      n.chg = (nx != s.ch) ? 1 : 0;
      n.out = int'((b >> (nx * 8)) & 64'hFF);
      n.ch  = nx;
    end
    return n;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: advance models with the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    m4 = mstep(m4, 4, 4, rst, hold, mode, int'(sel[1:0]), bus);
    m3 = mstep(m3, 3, 4, rst, hold, mode, int'(sel[1:0]), bus);
    m5 = mstep(m5, 5, 1, rst, hold, mode, int'(sel[2:0]), bus);
    #1;
    check("m4_out", int'(out4), m4.out);
    check("m4_ch",  int'(ch4),  m4.ch);
    check("m4_chg", int'(chg4), m4.chg);
    check("m3_out", int'(out3), m3.out);
    check("m3_ch",  int'(ch3),  m3.ch);
    check("m3_chg", int'(chg3), m3.chg);
    check("m5_out", int'(out5), m5.out);
    check("m5_ch",  int'(ch5),  m5.ch);
    check("m5_chg", int'(chg5), m5.chg);
  endtask

  typedef struct {
    bit          rst;
    bit          hold;
    bit          mode;
    int          sel;
    logic [31:0] bus;
    int          out;
    int          ch;
    int          chg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit r, bit h, bit md, int sl, logic [31:0] b, int o, int c, int g);
    vec_t v;
    v = '{r, h, md, sl, b, o, c, g};
    vecs.push_back(v);
  endtask

  task automatic add_n(int n, bit md, logic [31:0] b, int o, int c);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, md, 0, b, o, c, 0);
  endtask

  localparam logic [31:0] B  = 32'h4433_2211;
  localparam logic [31:0] HB = 32'h4433_AA11;

  initial begin
    // Reset and manual select
    add(1, 0, 0, 0, B, 'h00, 0, 0);
    add(1, 0, 0, 0, B, 'h00, 0, 0);
    add(0, 0, 0, 0, B, 'h11, 0, 0);
    add(0, 0, 0, 2, B, 'h33, 2, 1);
    add(0, 0, 0, 2, B, 'h33, 2, 0);
    add(0, 0, 0, 0, B, 'h11, 0, 1);
    // Scan through all channels with the 3->0 wrap
    add_n(3, 1, B, 'h11, 0);
    add(0, 0, 1, 0, B, 'h22, 1, 1); add_n(3, 1, B, 'h22, 1);
    add(0, 0, 1, 0, B, 'h33, 2, 1); add_n(3, 1, B, 'h33, 2);
    add(0, 0, 1, 0, B, 'h44, 3, 1); add_n(3, 1, B, 'h44, 3);
    add(0, 0, 1, 0, B, 'h11, 0, 1); add_n(3, 1, B, 'h11, 0);
    // Reach channel 1 with dwell position 2, then hold while its data changes
    add(0, 0, 1, 0, B, 'h22, 1, 1); add_n(2, 1, B, 'h22, 1);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 0, HB, 'h22, 1, 0);
    add(0, 0, 1, 0, HB, 'hAA, 1, 0);
    add(0, 0, 1, 0, HB, 'h33, 2, 1);
    // Scan -> manual takes sel at once; manual at 3 -> scan dwells then wraps to 0
    add(0, 0, 0, 0, B, 'h11, 0, 1);
    add(0, 0, 0, 3, B, 'h44, 3, 1);
    add_n(3, 1, B, 'h44, 3);
    add(0, 0, 1, 0, B, 'h11, 0, 1);
    // Reset together with hold mid-scan at channel 2, then restart from channel 0
    add(0, 0, 0, 2, B, 'h33, 2, 1);
    add(0, 0, 1, 0, B, 'h33, 2, 0);
    add(1, 1, 1, 0, B, 'h00, 0, 0);
    add_n(3, 1, B, 'h11, 0);
    add(0, 0, 1, 0, B, 'h22, 1, 1);

    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      hold = vecs[i].hold;
      mode = vecs[i].mode;
      sel  = 4'(vecs[i].sel);
      bus  = {32'h0, vecs[i].bus};
      tick();
      check($sformatf("vec%0d_out", i), int'(out4), vecs[i].out);
      check($sformatf("vec%0d_ch", i),  int'(ch4),  vecs[i].ch);
      check($sformatf("vec%0d_chg", i), int'(chg4), vecs[i].chg);
    end

    // Three-channel build: select 3 is ignored, scan wraps 2 -> 0
    bus  = {32'h0, B};
    rst  = 1'b1; hold = 1'b0; mode = 1'b0; sel = 4'd0;
    tick();
    rst = 1'b0; sel = 4'd1;
    tick();
    check("c3_sel1_ch", int'(ch3), 1);
    sel = 4'd3;
    tick();
    check("c3_oor_ch", int'(ch3), 1);
    check("c3_oor_chg", int'(chg3), 0);
    check("c3_oor_out", int'(out3), 'h22);
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 3) begin
        check("c3_step_ch", int'(ch3), 2);
        check("c3_step_chg", int'(chg3), 1);
      end
      if (i == 7) begin
        check("c3_wrap_ch", int'(ch3), 0);
        check("c3_wrap_chg", int'(chg3), 1);
        check("c3_wrap_out", int'(out3), 'h11);
      end
    end

    // Random stimulus against the model for all three builds
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(63) == 0);
      hold = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) mode = ~mode;
      sel  = 4'($urandom_range(7));
      if ($urandom_range(3) == 0) bus = {$urandom, $urandom};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
